// File: rtl/bsg_fifo_tracker_count_if.sv
// Handshake bundle between a FIFO pointer/occupancy tracker and its user:
// per-cycle enqueue/dequeue amounts in, RAM pointers and status flags out.
interface bsg_fifo_tracker_count_if #(
  parameter int unsigned els_p      = 256,
  parameter int unsigned max_step_p = 1
);
  localparam int unsigned pw = ($clog2(els_p) > 1) ? $clog2(els_p) : 1;
  localparam int unsigned cw = $clog2(els_p + 1);
  localparam int unsigned sw = $clog2(max_step_p + 1);

  logic [sw-1:0] enq_i;
  logic [sw-1:0] deq_i;
  logic [pw-1:0] wptr_r_o;
  logic [pw-1:0] rptr_r_o;
  logic [pw-1:0] rptr_n_o;
  logic [cw-1:0] count_r_o;
  logic          full_o;
  logic          empty_o;
  logic          almost_full_o;
  logic          err_r_o;

  modport master (
    output enq_i, deq_i,
    input  wptr_r_o, rptr_r_o, rptr_n_o, count_r_o,
    input  full_o, empty_o, almost_full_o, err_r_o
  );

  modport slave (
    input  enq_i, deq_i,
    output wptr_r_o, rptr_r_o, rptr_n_o, count_r_o,
    output full_o, empty_o, almost_full_o, err_r_o
  );
endinterface

// File: rtl/bsg_fifo_tracker_count.sv
// Multi-step pointer/occupancy tracker for a RAM-backed FIFO of any depth.
// Owns no storage; drives RAM addresses plus full/empty/almost-full/error status.
module bsg_fifo_tracker_count #(
  parameter int unsigned els_p      = 256,
  parameter int unsigned max_step_p = 1,
  parameter int unsigned slack_p    = 1
) (
  input logic                     clk_i,
  input logic                     reset_i,
  bsg_fifo_tracker_count_if.slave tr_if
);
  localparam int unsigned pw = ($clog2(els_p) > 1) ? $clog2(els_p) : 1;
  localparam int unsigned cw = $clog2(els_p + 1);
  localparam int unsigned sw = $clog2(max_step_p + 1);
  localparam int unsigned xw = cw + 1;

  logic [pw-1:0] wptr_q, wptr_d;
  logic [pw-1:0] rptr_q, rptr_d;
  logic [cw-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          err_q, err_d;

  logic          enq_ok, deq_ok;
  logic [sw-1:0] enq_eff, deq_eff;
  logic [xw-1:0] free_x, count_x, free_next_x;

  // Modular advance; the sum is one bit wider so non-power-of-two depths wrap correctly.
  function automatic logic [pw-1:0] ptr_add(input logic [pw-1:0] p, input logic [sw-1:0] k);
    logic [pw:0] sum;
    sum = (pw+1)'(p) + (pw+1)'(k);
    if (sum >= (pw+1)'(els_p)) ptr_add = pw'(sum - (pw+1)'(els_p));
    else                       ptr_add = pw'(sum);
  endfunction

  // Legality is judged against registered occupancy only, so no same-cycle bypass exists.
  always_comb begin
    free_x      = xw'(els_p) - xw'(count_q);
    enq_ok      = (xw'(tr_if.enq_i) <= xw'(max_step_p)) && (xw'(tr_if.enq_i) <= free_x);
    deq_ok      = (xw'(tr_if.deq_i) <= xw'(max_step_p)) && (xw'(tr_if.deq_i) <= xw'(count_q));
    enq_eff     = enq_ok ? tr_if.enq_i : '0;
    deq_eff     = deq_ok ? tr_if.deq_i : '0;

    wptr_d      = ptr_add(wptr_q, enq_eff);
    rptr_d      = ptr_add(rptr_q, deq_eff);
    count_x     = xw'(count_q) + xw'(enq_eff) - xw'(deq_eff);
    count_d     = cw'(count_x);
    free_next_x = xw'(els_p) - xw'(count_d);

    full_d      = (count_d == cw'(els_p));
    empty_d     = (count_d == '0);
    afull_d     = (free_next_x <= xw'(slack_p));
    err_d       = err_q | ~enq_ok | ~deq_ok;
  end

  // Flags are registered alongside the count they are derived from.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      afull_q <= (els_p <= slack_p);
      err_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      afull_q <= afull_d;
      err_q   <= err_d;
    end
  end

  assign tr_if.wptr_r_o      = wptr_q;
  assign tr_if.rptr_r_o      = rptr_q;
  assign tr_if.rptr_n_o      = rptr_d;
  assign tr_if.count_r_o     = count_q;
  assign tr_if.full_o        = full_q;
  assign tr_if.empty_o       = empty_q;
  assign tr_if.almost_full_o = afull_q;
  assign tr_if.err_r_o       = err_q;

  // Step amounts beyond max_step_p indicate a broken upstream.
  enq_step_a: assert property (@(posedge clk_i) disable iff (reset_i)
    xw'(tr_if.enq_i) <= xw'(max_step_p))
    else $error("bsg_fifo_tracker_count: enq_i exceeds max_step_p");
  deq_step_a: assert property (@(posedge clk_i) disable iff (reset_i)
    xw'(tr_if.deq_i) <= xw'(max_step_p))
    else $error("bsg_fifo_tracker_count: deq_i exceeds max_step_p");

  // Marks the first illegal request, i.e. the moment the sticky error latches.
  first_illegal_c: cover property (@(posedge clk_i) disable iff (reset_i)
    !err_q && !(enq_ok && deq_ok));
endmodule

// File: tb/tb_bsg_fifo_tracker_count.sv
// Bench for bsg_fifo_tracker_count: directed scenarios on a 6-deep, 2-step
// instance plus randomized traffic on both a small and a 256-deep instance.
module tb_bsg_fifo_tracker_count;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bsg_fifo_tracker_count_if #(.els_p(6),   .max_step_p(2)) ifa ();
  bsg_fifo_tracker_count_if #(.els_p(256), .max_step_p(1)) ifb ();

  bsg_fifo_tracker_count #(.els_p(6), .max_step_p(2), .slack_p(1)) dut_a (
    .clk_i(clk), .reset_i(rst_a), .tr_if(ifa)
  );
  bsg_fifo_tracker_count #(.els_p(256), .max_step_p(1), .slack_p(0)) dut_b (
    .clk_i(clk), .reset_i(rst_b), .tr_if(ifb)
  );

  task automatic tick_a(input int e, input int d);
    ifa.enq_i = 2'(e);
    ifa.deq_i = 2'(d);
    @(posedge clk); #1;
  endtask

  // Mid-cycle asynchronous reset pulse, released well before the next edge.
  task automatic pulse_reset_a();
    ifa.enq_i = '0; ifa.deq_i = '0;
    rst_a = 1'b1; #1; rst_a = 1'b0; #1;
  endtask

  task automatic test_reset();
    ifa.enq_i = '0; ifa.deq_i = '0;
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({ifa.wptr_r_o, ifa.rptr_r_o, ifa.rptr_n_o, ifa.count_r_o} !== 12'h000) begin
      errors++; $display("FAIL reset_ptrs: got w=%0d r=%0d rn=%0d c=%0d want all 0",
        ifa.wptr_r_o, ifa.rptr_r_o, ifa.rptr_n_o, ifa.count_r_o);
    end
    checks++;
    if ({ifa.full_o, ifa.empty_o, ifa.almost_full_o, ifa.err_r_o} !== 4'b0100) begin
      errors++; $display("FAIL reset_flags: got f/e/af/err=%b want 0100",
        {ifa.full_o, ifa.empty_o, ifa.almost_full_o, ifa.err_r_o});
    end
  endtask

  task automatic test_async_reset();
    tick_a(2, 0);
    tick_a(1, 0);
    ifa.enq_i = '0; ifa.deq_i = '0;
    checks++;
    if (ifa.count_r_o !== 3'd3) begin
      errors++; $display("FAIL async_pre_count: got %0d want 3", ifa.count_r_o);
    end
    #2 rst_a = 1'b1;
    #1;
    checks++;
    if ({ifa.wptr_r_o, ifa.count_r_o, ifa.empty_o} !== 7'b000_000_1) begin
      errors++; $display("FAIL async_clear: got w=%0d c=%0d empty=%b want 0 0 1",
        ifa.wptr_r_o, ifa.count_r_o, ifa.empty_o);
    end
    @(posedge clk); #1;
    rst_a = 1'b0;
  endtask

  task automatic test_fill();
    int exp_c[3]  = '{2, 4, 6};
    int exp_w[3]  = '{2, 4, 0};
    bit exp_af[3] = '{1'b0, 1'b0, 1'b1};
    bit exp_f[3]  = '{1'b0, 1'b0, 1'b1};
    pulse_reset_a();
    for (int i = 0; i < 3; i++) begin
      tick_a(2, 0);
      checks++;
      if (ifa.count_r_o !== 3'(exp_c[i]) || ifa.wptr_r_o !== 3'(exp_w[i])) begin
        errors++; $display("FAIL fill_%0d_cw: got c=%0d w=%0d want c=%0d w=%0d",
          i, ifa.count_r_o, ifa.wptr_r_o, exp_c[i], exp_w[i]);
      end
      checks++;
      if (ifa.almost_full_o !== exp_af[i] || ifa.full_o !== exp_f[i] || ifa.err_r_o !== 1'b0) begin
        errors++; $display("FAIL fill_%0d_flags: got af=%b f=%b err=%b want af=%b f=%b err=0",
          i, ifa.almost_full_o, ifa.full_o, ifa.err_r_o, exp_af[i], exp_f[i]);
      end
    end
  endtask

  // Runs straight after test_fill, so the FIFO is full with wptr=0, rptr=0.
  task automatic test_full_drop();
    tick_a(1, 1);
    checks++;
    if ({ifa.count_r_o, ifa.rptr_r_o, ifa.wptr_r_o} !== {3'd5, 3'd1, 3'd0}) begin
      errors++; $display("FAIL full_drop_state: got c=%0d r=%0d w=%0d want 5 1 0",
        ifa.count_r_o, ifa.rptr_r_o, ifa.wptr_r_o);
    end
    checks++;
    if ({ifa.err_r_o, ifa.full_o, ifa.almost_full_o} !== 3'b101) begin
      errors++; $display("FAIL full_drop_flags: got err/f/af=%b want 101",
        {ifa.err_r_o, ifa.full_o, ifa.almost_full_o});
    end
    tick_a(0, 0);
    tick_a(0, 1);
    checks++;
    if (ifa.err_r_o !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got %b want 1", ifa.err_r_o);
    end
  endtask

  task automatic test_stream();
    pulse_reset_a();
    tick_a(2, 0); tick_a(2, 0); tick_a(1, 0);
    tick_a(0, 2); tick_a(0, 2); tick_a(0, 1);
    tick_a(2, 0); tick_a(1, 0);
    checks++;
    if ({ifa.count_r_o, ifa.rptr_r_o, ifa.wptr_r_o} !== {3'd3, 3'd5, 3'd2}) begin
      errors++; $display("FAIL stream_setup: got c=%0d r=%0d w=%0d want 3 5 2",
        ifa.count_r_o, ifa.rptr_r_o, ifa.wptr_r_o);
    end
    ifa.enq_i = 2'd2; ifa.deq_i = 2'd2;
    #1;
    checks++;
    if (ifa.rptr_n_o !== 3'd1) begin
      errors++; $display("FAIL stream_rptr_n0: got %0d want 1", ifa.rptr_n_o);
    end
    @(posedge clk); #1;
    checks++;
    if ({ifa.count_r_o, ifa.rptr_r_o, ifa.wptr_r_o} !== {3'd3, 3'd1, 3'd4}) begin
      errors++; $display("FAIL stream_step1: got c=%0d r=%0d w=%0d want 3 1 4",
        ifa.count_r_o, ifa.rptr_r_o, ifa.wptr_r_o);
    end
    checks++;
    if (ifa.rptr_n_o !== 3'd3) begin
      errors++; $display("FAIL stream_rptr_n1: got %0d want 3", ifa.rptr_n_o);
    end
    @(posedge clk); #1;
    checks++;
    if ({ifa.count_r_o, ifa.rptr_r_o, ifa.wptr_r_o, ifa.err_r_o} !== {3'd3, 3'd3, 3'd0, 1'b0}) begin
      errors++; $display("FAIL stream_step2: got c=%0d r=%0d w=%0d err=%b want 3 3 0 0",
        ifa.count_r_o, ifa.rptr_r_o, ifa.wptr_r_o, ifa.err_r_o);
    end
  endtask

  task automatic test_empty_drop();
    pulse_reset_a();
    ifa.enq_i = 2'd2; ifa.deq_i = 2'd1;
    #1;
    checks++;
    if (ifa.rptr_n_o !== 3'd0 || ifa.empty_o !== 1'b1) begin
      errors++; $display("FAIL empty_drop_pre: got rn=%0d empty=%b want 0 1",
        ifa.rptr_n_o, ifa.empty_o);
    end
    @(posedge clk); #1;
    checks++;
    if ({ifa.count_r_o, ifa.rptr_r_o, ifa.err_r_o, ifa.empty_o} !== {3'd2, 3'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL empty_drop_post: got c=%0d r=%0d err=%b empty=%b want 2 0 1 0",
        ifa.count_r_o, ifa.rptr_r_o, ifa.err_r_o, ifa.empty_o);
    end
    ifa.enq_i = '0; ifa.deq_i = '0;
    #1;
    checks++;
    if (ifa.rptr_n_o !== 3'd0) begin
      errors++; $display("FAIL empty_drop_rn: got %0d want 0", ifa.rptr_n_o);
    end
  endtask

  // Model: pointers are running totals mod depth; occupancy is their difference.
  task automatic test_random_a(input int n);
    int te, td, cnt, e, d, ea, da;
    bit el, dl, err;
    te = 0; td = 0; err = 1'b0;
    pulse_reset_a();
    for (int i = 0; i < n; i++) begin
      e = $urandom_range(0, 2);
      d = $urandom_range(0, 2);
      cnt = te - td;
      el = (e <= 6 - cnt);
      dl = (d <= cnt);
      ea = el ? e : 0;
      da = dl ? d : 0;
      ifa.enq_i = 2'(e); ifa.deq_i = 2'(d);
      #1;
      checks++;
      if (ifa.rptr_n_o !== 3'((td + da) % 6)) begin
        errors++; $display("FAIL rnd_a_rptr_n[%0d]: got %0d want %0d", i, ifa.rptr_n_o, (td + da) % 6);
      end
      @(posedge clk); #1;
      te += ea; td += da;
      if (!el || !dl) err = 1'b1;
      cnt = te - td;
      checks++;
      if (ifa.wptr_r_o !== 3'(te % 6) || ifa.rptr_r_o !== 3'(td % 6) || ifa.count_r_o !== 3'(cnt)) begin
        errors++; $display("FAIL rnd_a_state[%0d]: got w=%0d r=%0d c=%0d want %0d %0d %0d",
          i, ifa.wptr_r_o, ifa.rptr_r_o, ifa.count_r_o, te % 6, td % 6, cnt);
      end
      checks++;
      if (ifa.full_o !== (cnt == 6) || ifa.empty_o !== (cnt == 0) ||
          ifa.almost_full_o !== (6 - cnt <= 1) || ifa.err_r_o !== err) begin
        errors++; $display("FAIL rnd_a_flags[%0d]: got f/e/af/err=%b%b%b%b count=%0d err_exp=%b",
          i, ifa.full_o, ifa.empty_o, ifa.almost_full_o, ifa.err_r_o, cnt, err);
      end
    end
  endtask

  // Scoreboard queue holds the RAM slot of every live entry, oldest first.
  task automatic test_random_b(input int n);
    int q[$];
    int te, td, e, d, slot, full_eq, empty_eq;
    bit fill;
    te = 0; td = 0; full_eq = 0; empty_eq = 0;
    ifb.enq_i = '0; ifb.deq_i = '0;
    rst_b = 1'b1; #1; rst_b = 1'b0; #1;
    for (int i = 0; i < n; i++) begin
      fill = ((i / 700) % 2) == 0;
      e = ($urandom_range(0, 3) < (fill ? 3 : 1)) ? 1 : 0;
      d = ($urandom_range(0, 3) < (fill ? 1 : 3)) ? 1 : 0;
      if (q.size() == 256) e = 0;
      if (q.size() == 0)   d = 0;
      ifb.enq_i = 1'(e); ifb.deq_i = 1'(d);
      #1;
      if (d == 1) begin
        slot = q.pop_front();
        checks++;
        if (ifb.rptr_r_o !== 8'(slot)) begin
          errors++; $display("FAIL rnd_b_oldest[%0d]: got %0d want %0d", i, ifb.rptr_r_o, slot);
        end
      end
      checks++;
      if (ifb.rptr_n_o !== 8'((td + d) % 256)) begin
        errors++; $display("FAIL rnd_b_rptr_n[%0d]: got %0d want %0d", i, ifb.rptr_n_o, (td + d) % 256);
      end
      if (e == 1) q.push_back(te % 256);
      @(posedge clk); #1;
      te += e; td += d;
      checks++;
      if (ifb.count_r_o !== 9'(q.size()) || ifb.wptr_r_o !== 8'(te % 256) || ifb.rptr_r_o !== 8'(td % 256)) begin
        errors++; $display("FAIL rnd_b_state[%0d]: got c=%0d w=%0d r=%0d want %0d %0d %0d",
          i, ifb.count_r_o, ifb.wptr_r_o, ifb.rptr_r_o, q.size(), te % 256, td % 256);
      end
      checks++;
      if (ifb.full_o !== (q.size() == 256) || ifb.empty_o !== (q.size() == 0) ||
          ifb.almost_full_o !== (q.size() == 256) || ifb.err_r_o !== 1'b0) begin
        errors++; $display("FAIL rnd_b_flags[%0d]: got f/e/af/err=%b%b%b%b size=%0d",
          i, ifb.full_o, ifb.empty_o, ifb.almost_full_o, ifb.err_r_o, q.size());
      end
      if ((te % 256) == (td % 256)) begin
        if (q.size() == 256) full_eq++;
        if (q.size() == 0)   empty_eq++;
      end
    end
    ifb.enq_i = '0; ifb.deq_i = '0;
    checks++;
    if (full_eq == 0 || empty_eq == 0) begin
      errors++; $display("FAIL rnd_b_coverage: full_at_eq=%0d empty_at_eq=%0d want both > 0",
        full_eq, empty_eq);
    end
  endtask

  initial begin
    ifa.enq_i = '0; ifa.deq_i = '0;
    ifb.enq_i = '0; ifb.deq_i = '0;
    test_reset();
    test_async_reset();
    test_fill();
    test_full_drop();
    test_stream();
    test_empty_drop();
    test_random_a(400);
    test_random_b(10000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
